// File: rtl/major_comparator_pkg.sv
// -----------------------------------------------------------------------------
// major_comparator_pkg
// Shared definitions for the registered magnitude comparator / max selector.
//   DEFAULT_WIDTH : operand width used when no override is given
//   cmp_rel_t     : encoded relation of operand A to operand B
// -----------------------------------------------------------------------------
package major_comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    REL_LT = 2'd0,
    REL_EQ = 2'd1,
    REL_GT = 2'd2
  } cmp_rel_t;

endpackage : major_comparator_pkg

// File: rtl/major_comparator_if.sv
// -----------------------------------------------------------------------------
// major_comparator_if
// Operand / result bundle for major_comparator.
//   a, b         : operands (WIDTH bits)
//   in_valid     : operands valid this cycle
//   signed_mode  : 0 = unsigned compare, 1 = two's-complement compare
//   y            : registered max(a, b)
//   a_gt_b/a_eq_b/a_lt_b : registered one-hot relation flags
//   out_valid    : registered copy of in_valid
// master drives operands and observes results; slave is the comparator side.
// -----------------------------------------------------------------------------
interface major_comparator_if
  import major_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             signed_mode;
  logic [WIDTH-1:0] y;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
  logic             out_valid;

  modport master (
    output a, b, in_valid, signed_mode,
    input  y, a_gt_b, a_eq_b, a_lt_b, out_valid
  );

  modport slave (
    input  a, b, in_valid, signed_mode,
    output y, a_gt_b, a_eq_b, a_lt_b, out_valid
  );

endinterface : major_comparator_if

// File: rtl/comparator_slice.sv
// -----------------------------------------------------------------------------
// comparator_slice
// One-bit cell of an MSB-first magnitude compare cascade. Once a higher slice
// has decided (gt_in or lt_in set) the decision passes through unchanged;
// otherwise this bit decides if a_i and b_i differ.
//   a_i, b_i        : operand bits for this position
//   gt_in, lt_in    : decision from the next-more-significant slice
//   gt_out, lt_out  : decision after including this bit
// -----------------------------------------------------------------------------
module comparator_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic gt_in,
  input  logic lt_in,
  output logic gt_out,
  output logic lt_out
);

  assign gt_out = gt_in | (~lt_in & a_i & ~b_i);
  assign lt_out = lt_in | (~gt_in & ~a_i & b_i);

endmodule : comparator_slice

// File: rtl/major_comparator.sv
// -----------------------------------------------------------------------------
// major_comparator
// Registered magnitude comparator with max selector, one pipeline stage.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (clears every output)
//   bus  : major_comparator_if.slave (operands in, registered results out)
// A beat sampled with in_valid = 1 loads y / flags on the next edge and pulses
// out_valid; with in_valid = 0 the previous result is held and out_valid = 0.
// -----------------------------------------------------------------------------
module major_comparator
  import major_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  major_comparator_if.slave   bus
);

  // Compare cascade, slice WIDTH-1 (MSB) feeds downwards to slice 0.
  // Each slice keeps its own wires so the chain has no self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic a_bit_s;
    logic b_bit_s;
    logic gt_in_s;
    logic lt_in_s;
    logic gt_out_s;
    logic lt_out_s;

    if (i == WIDTH - 1) begin : g_msb
      // In two's complement a set MSB means negative, so swapping the MSB
      // operands makes the MSB=0 operand win when the signs differ.
      assign a_bit_s = bus.signed_mode ? bus.b[i] : bus.a[i];
      assign b_bit_s = bus.signed_mode ? bus.a[i] : bus.b[i];
      assign gt_in_s = 1'b0;
      assign lt_in_s = 1'b0;
    end else begin : g_lower
      assign a_bit_s = bus.a[i];
      assign b_bit_s = bus.b[i];
      assign gt_in_s = g_slice[i+1].gt_out_s;
      assign lt_in_s = g_slice[i+1].lt_out_s;
    end

    comparator_slice u_slice (
      .a_i    (a_bit_s),
      .b_i    (b_bit_s),
      .gt_in  (gt_in_s),
      .lt_in  (lt_in_s),
      .gt_out (gt_out_s),
      .lt_out (lt_out_s)
    );
  end

  logic     gt_s;
  logic     lt_s;
  logic     eq_s;
  cmp_rel_t rel_s;

  assign gt_s = g_slice[0].gt_out_s;
  assign lt_s = g_slice[0].lt_out_s;
  assign eq_s = ~gt_s & ~lt_s;

  logic [WIDTH-1:0] y_q,   y_d;
  logic             gt_q,  gt_d;
  logic             eq_q,  eq_d;
  logic             lt_q,  lt_d;
  logic             vld_q, vld_d;

  // Encode the cascade result as a single relation value.
  always_comb begin
    rel_s = REL_EQ;
    if (gt_s) begin
      rel_s = REL_GT;
    end else if (lt_s) begin
      rel_s = REL_LT;
    end else if (eq_s) begin
      rel_s = REL_EQ;
    end else begin
      rel_s = REL_EQ;
    end
  end

  // Next-state: load result on a valid beat, otherwise hold y and flags.
  always_comb begin
    y_d   = y_q;
    gt_d  = gt_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    vld_d = 1'b0;
    if (bus.in_valid) begin
      vld_d = 1'b1;
      case (rel_s)
        REL_GT: begin
          y_d  = bus.a;
          gt_d = 1'b1;
          eq_d = 1'b0;
          lt_d = 1'b0;
        end
        REL_EQ: begin
          y_d  = bus.a;
          gt_d = 1'b0;
          eq_d = 1'b1;
          lt_d = 1'b0;
        end
        REL_LT: begin
          y_d  = bus.b;
          gt_d = 1'b0;
          eq_d = 1'b0;
          lt_d = 1'b1;
        end
        default: begin
          y_d  = y_q;
          gt_d = gt_q;
          eq_d = eq_q;
          lt_d = lt_q;
        end
      endcase
    end else begin
      vld_d = 1'b0;
    end
  end

  // Output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= {WIDTH{1'b0}};
      gt_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      gt_q  <= gt_d;
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      vld_q <= vld_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.a_gt_b    = gt_q;
  assign bus.a_eq_b    = eq_q;
  assign bus.a_lt_b    = lt_q;
  assign bus.out_valid = vld_q;

endmodule : major_comparator

// File: tb/tb_major_comparator.sv
// -----------------------------------------------------------------------------
// tb_major_comparator
// Directed bench for major_comparator (WIDTH = 8). Inputs change on the falling
// edge; outputs are sampled 1 ns after the rising edge that registers them.
// -----------------------------------------------------------------------------
module tb_major_comparator;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  major_comparator_if #(.WIDTH(W)) bus ();

  major_comparator #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare all outputs against expected {y, gt, eq, lt, out_valid}.
  task automatic chk(input string tag, input logic [W-1:0] ey,
                     input logic eg, input logic ee, input logic el,
                     input logic ev);
    logic [W+3:0] obs;
    logic [W+3:0] exp_v;
    obs   = {bus.y, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b, bus.out_valid};
    exp_v = {ey, eg, ee, el, ev};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed y=%h gt/eq/lt=%b%b%b ov=%b, expected y=%h gt/eq/lt=%b%b%b ov=%b",
             tag, bus.y, bus.a_gt_b, bus.a_eq_b, bus.a_lt_b, bus.out_valid,
             ey, eg, ee, el, ev);
    end
  endtask

  // Drive one beat on the falling edge, then wait until just after it registers.
  task automatic beat(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic v, input logic s);
    @(negedge clk);
    bus.a           = av;
    bus.b           = bv;
    bus.in_valid    = v;
    bus.signed_mode = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.a           = 8'h00;
    bus.b           = 8'h00;
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;

    // Reset state, and reset dominating clock edges with a valid beat present.
    #1;
    chk("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'h55, 8'h22, 1'b1, 1'b0);
    chk("reset_dominates_clk", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Unsigned basic sweep.
    beat(8'h00, 8'h00, 1'b1, 1'b0); chk("u_00_00", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(8'h00, 8'h01, 1'b1, 1'b0); chk("u_00_01", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'h04, 8'h03, 1'b1, 1'b0); chk("u_04_03", 8'h04, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(8'h03, 8'h04, 1'b1, 1'b0); chk("u_03_04", 8'h04, 1'b0, 1'b0, 1'b1, 1'b1);

    // Multi-bit differences, unsigned.
    beat(8'h40, 8'h35, 1'b1, 1'b0); chk("u_40_35", 8'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(8'h05, 8'h08, 1'b1, 1'b0); chk("u_05_08", 8'h08, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'h20, 8'h17, 1'b1, 1'b0); chk("u_20_17", 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);

    // MSB cases, unsigned.
    beat(8'hCA, 8'h7B, 1'b1, 1'b0); chk("u_CA_7B", 8'hCA, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(8'hCA, 8'hFB, 1'b1, 1'b0); chk("u_CA_FB", 8'hFB, 1'b0, 1'b0, 1'b1, 1'b1);

    // Signed mode.
    beat(8'hCA, 8'h7B, 1'b1, 1'b1); chk("s_CA_7B", 8'h7B, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'hCA, 8'hFB, 1'b1, 1'b1); chk("s_CA_FB", 8'hFB, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'h80, 8'h7F, 1'b1, 1'b1); chk("s_80_7F", 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'hFF, 8'hFF, 1'b1, 1'b1); chk("s_FF_FF", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(8'h7F, 8'h80, 1'b1, 1'b1); chk("s_7F_80", 8'h7F, 1'b1, 0, 1'b0, 1'b1);

    // Valid / hold.
    beat(8'h10, 8'h20, 1'b1, 1'b0); chk("hold_load", 8'h20, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'hFF, 8'h00, 1'b0, 1'b0); chk("hold_idle", 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(8'hFF, 8'h00, 1'b0, 1'b1); chk("hold_idle2", 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back valid beats, one result per cycle in order.
    beat(8'h11, 8'h10, 1'b1, 1'b0); chk("b2b_0", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(8'h09, 8'h0A, 1'b1, 1'b0); chk("b2b_1", 8'h0A, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(8'h33, 8'h33, 1'b1, 1'b0); chk("b2b_2", 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);

    // Async reset asserted between clock edges while y = 0xFB.
    beat(8'hCA, 8'hFB, 1'b1, 1'b1); chk("pre_reset", 8'hFB, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    beat(8'h03, 8'h04, 1'b1, 1'b0); chk("post_reset", 8'h04, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_major_comparator
